half_adder_1b: RTL and testbench
================================

Name: half_adder_1b

Overview:
- Single-bit half adder: sum = a XOR b, carry = a AND b.
- Leaf arithmetic cell of the 8-bit CPU ALU; chained by higher-level adders.
- Output path selectable at elaboration: purely combinational (default) or registered with a valid strobe.
- Optional saturating carry-event counter for ALU debug/coverage.

Parameters:
- REG_OUT, 0, 0 = combinational outputs (latency 0); 1 = registered outputs (latency 1 clk).
- CNT_W, 8, width of carry_count (legal range 1..32).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous reset, active-high.
- input_a  input  1  operand A.
- input_b  input  1  operand B.
- in_valid  input  1  operands valid this cycle; tie high when unused.
- output_carry  output  1  carry out = A AND B.
- output_sum  output  1  sum = A XOR B.
- out_valid  output  1  output_carry/output_sum valid.
- carry_count  output  CNT_W  number of valid operations that produced carry=1 (saturating).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Truth table (A,B -> carry,sum): 00->00, 10->01, 01->01, 11->10.
- REG_OUT=0:
  - output_sum = input_a ^ input_b and output_carry = input_a & input_b, continuously.
  - Independent of clk, rst and in_valid.
  - out_valid = in_valid, combinationally.
  - rst has no effect on these three outputs.
- REG_OUT=1:
  - On each rising clk with rst=1: output_carry=0, output_sum=0, out_valid=0.
  - Else, if in_valid=1: register the carry/sum of the current inputs; out_valid<=1.
  - Else: hold output_carry/output_sum; out_valid<=0.
  - Latency exactly 1 cycle; one result per cycle; no backpressure.
- Reset values (REG_OUT=1): output_carry=0, output_sum=0, out_valid=0, carry_count=0.
- rst asserted mid-stream: the cycle's in_valid is ignored; the next cycle after deassert operates normally.
- X/Z inputs: no requirement; the bench drives only 0/1.
- carry_count:
  - Always registered, regardless of REG_OUT.
  - Clears to 0 on rst.
  - Increments by 1 on each rising clk where in_valid=1 and input_a=input_b=1.
  - Saturates at 2^CNT_W-1; never wraps.
  - rst has priority over increment in the same cycle.

Optional Feature:
- Macro HALF_ADDER_1B_CARRY_COUNT_EN.
- Defined: carry_count logic compiled in, as described above.
- Undefined: counter logic removed; carry_count port still present and driven constant 0.
- The sum/carry path is identical in both builds.

Test Plan:
- REG_OUT=0, in_valid=1; drive (A,B) = 00, 10, 01, 11, holding each 100 time units -> (carry,sum) = 00, 01, 01, 10, valid within the same delta; out_valid=1.
- REG_OUT=1; hold rst=1 for 2 clks -> carry=sum=out_valid=0, carry_count=0. Release rst, apply A=B=1, in_valid=1 -> next clk: carry=1, sum=0, out_valid=1.
- REG_OUT=1; in_valid=1 with A=1,B=0, then in_valid=0 with A=B=1 -> outputs hold carry=0, sum=1; out_valid falls to 0.
- COUNT_EN defined, CNT_W=2; 5 consecutive valid cycles of A=B=1 -> carry_count = 1, 2, 3, 3, 3 (saturated). Then rst asserted in a cycle with A=B=1 -> carry_count=0.
- COUNT_EN undefined; 10 valid cycles of A=B=1 -> carry_count stays 0 while sum/carry remain correct.
- REG_OUT=1; assert rst for one cycle between two valid operations -> outputs and out_valid read 0 in that cycle; the following valid operation produces the correct result one clk later.

Source files
------------

// File: rtl/half_adder_1b.sv
// half_adder_1b: single-bit half adder cell for the 8-bit CPU ALU.
//   sum = a ^ b, carry = a & b.
//   REG_OUT = 0 : combinational sum/carry/valid (latency 0).
//   REG_OUT = 1 : registered sum/carry/valid (latency 1 clk), sync active-high rst.
// Optional build macro HALF_ADDER_1B_CARRY_COUNT_EN compiles in a saturating
// counter of valid operations that produced a carry; without it carry_count
// is tied to zero.
module half_adder_1b #(
  parameter int unsigned REG_OUT = 0,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             input_a,
  input  logic             input_b,
  input  logic             in_valid,
  output logic             output_carry,
  output logic             output_sum,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_count
);

  // Raw arithmetic of the current operands, shared by every output path.
  logic sum_s;
  logic carry_s;
  assign sum_s   = input_a ^ input_b;
  assign carry_s = input_a & input_b;

  // clk/rst are legitimately unused in the all-combinational build.
  logic unused_s;
  assign unused_s = ^{clk, rst};

  generate
    if (REG_OUT == 1) begin : g_reg
      logic carry_d, carry_q;
      logic sum_d, sum_q;
      logic valid_d, valid_q;

      // Next-state: capture new result on a valid cycle, otherwise hold the data.
      always_comb begin
        carry_d = carry_q;
        sum_d   = sum_q;
        valid_d = 1'b0;
        if (in_valid) begin
          carry_d = carry_s;
          sum_d   = sum_s;
          valid_d = 1'b1;
        end else begin
          carry_d = carry_q;
          sum_d   = sum_q;
          valid_d = 1'b0;
        end
      end

      // Output registers with synchronous reset taking priority over capture.
      always_ff @(posedge clk) begin
        if (rst) begin
          carry_q <= 1'b0;
          sum_q   <= 1'b0;
          valid_q <= 1'b0;
        end else begin
          carry_q <= carry_d;
          sum_q   <= sum_d;
          valid_q <= valid_d;
        end
      end

      assign output_carry = carry_q;
      assign output_sum   = sum_q;
      assign out_valid    = valid_q;
    end else begin : g_comb
      assign output_carry = carry_s;
      assign output_sum   = sum_s;
      assign out_valid    = in_valid;
    end
  endgenerate

`ifdef HALF_ADDER_1B_CARRY_COUNT_EN
  logic [CNT_W-1:0] count_d, count_q;
  logic             count_max_s;
  assign count_max_s = (count_q == {CNT_W{1'b1}});

  // Next count: bump on a valid carry-producing operation, stick at all-ones.
  always_comb begin
    count_d = count_q;
    if (in_valid && carry_s && !count_max_s) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register; reset wins over an increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign carry_count = count_q;
`else
  assign carry_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_half_adder_1b.sv
// Directed bench for half_adder_1b: one combinational instance (REG_OUT=0,
// CNT_W=8) and one registered instance (REG_OUT=1, CNT_W=2) share the stimulus.
// Counter expectations follow HALF_ADDER_1B_CARRY_COUNT_EN (zero when undefined).
module tb_half_adder_1b;

`ifdef HALF_ADDER_1B_CARRY_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       a;
  logic       b;
  logic       in_valid;
  logic       c0_carry, c0_sum, c0_valid;
  logic [7:0] c0_count;
  logic       r_carry, r_sum, r_valid;
  logic [1:0] r_count;

  int checks = 0;
  int errors = 0;

  half_adder_1b #(.REG_OUT(0), .CNT_W(8)) u_comb (
    .clk(clk), .rst(rst), .input_a(a), .input_b(b), .in_valid(in_valid),
    .output_carry(c0_carry), .output_sum(c0_sum), .out_valid(c0_valid),
    .carry_count(c0_count)
  );

  half_adder_1b #(.REG_OUT(1), .CNT_W(2)) u_reg (
    .clk(clk), .rst(rst), .input_a(a), .input_b(b), .in_valid(in_valid),
    .output_carry(r_carry), .output_sum(r_sum), .out_valid(r_valid),
    .carry_count(r_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; a = 1'b0; b = 1'b0; in_valid = 1'b0;
    tick; tick;
    checks++;
    if ({r_carry, r_sum, r_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_reg_outputs: got %b expected 000", {r_carry, r_sum, r_valid});
    end
    checks++;
    if (r_count !== 2'd0) begin
      errors++; $display("FAIL reset_reg_count: got %0d expected 0", r_count);
    end
    checks++;
    if (c0_count !== 8'd0) begin
      errors++; $display("FAIL reset_comb_count: got %0d expected 0", c0_count);
    end
    a = 1'b1; b = 1'b0; in_valid = 1'b1;
    #1;
    checks++;
    if ({c0_carry, c0_sum, c0_valid} !== 3'b011) begin
      errors++; $display("FAIL reset_comb_ignores_rst: got %b expected 011", {c0_carry, c0_sum, c0_valid});
    end
    tick;
    checks++;
    if ({r_carry, r_sum, r_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_ignores_valid: got %b expected 000", {r_carry, r_sum, r_valid});
    end
  endtask

  task automatic test_comb;
    logic [1:0] vin [4];
    logic [1:0] vexp [4];
    vin  = '{2'b00, 2'b10, 2'b01, 2'b11};
    vexp = '{2'b00, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      {a, b} = vin[i];
      in_valid = 1'b1;
      #1;
      checks++;
      if ({c0_carry, c0_sum, c0_valid} !== {vexp[i], 1'b1}) begin
        errors++; $display("FAIL comb_vec%0d: got %b expected %b", i, {c0_carry, c0_sum, c0_valid}, {vexp[i], 1'b1});
      end
      #99;
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if ({c0_carry, c0_sum, c0_valid} !== 3'b100) begin
      errors++; $display("FAIL comb_valid_low: got %b expected 100", {c0_carry, c0_sum, c0_valid});
    end
  endtask

  task automatic test_reg_basic;
    tick;
    rst = 1'b0; a = 1'b1; b = 1'b1; in_valid = 1'b1;
    tick;
    checks++;
    if ({r_carry, r_sum, r_valid} !== 3'b101) begin
      errors++; $display("FAIL reg_basic_11: got %b expected 101", {r_carry, r_sum, r_valid});
    end
    checks++;
    if (r_count !== (CNT_EN ? 2'd1 : 2'd0)) begin
      errors++; $display("FAIL reg_basic_count: got %0d expected %0d", r_count, (CNT_EN ? 1 : 0));
    end
    checks++;
    if (c0_count !== (CNT_EN ? 8'd1 : 8'd0)) begin
      errors++; $display("FAIL comb_basic_count: got %0d expected %0d", c0_count, (CNT_EN ? 1 : 0));
    end
  endtask

  task automatic test_hold;
    a = 1'b1; b = 1'b0; in_valid = 1'b1;
    tick;
    checks++;
    if ({r_carry, r_sum, r_valid} !== 3'b011) begin
      errors++; $display("FAIL hold_load_10: got %b expected 011", {r_carry, r_sum, r_valid});
    end
    a = 1'b1; b = 1'b1; in_valid = 1'b0;
    tick;
    checks++;
    if ({r_carry, r_sum, r_valid} !== 3'b010) begin
      errors++; $display("FAIL hold_invalid: got %b expected 010", {r_carry, r_sum, r_valid});
    end
    checks++;
    if (r_count !== (CNT_EN ? 2'd1 : 2'd0)) begin
      errors++; $display("FAIL hold_count_no_inc: got %0d expected %0d", r_count, (CNT_EN ? 1 : 0));
    end
  endtask

  task automatic test_count_sat;
    int exp_r;
    int exp_c;
    rst = 1'b1;
    tick;
    checks++;
    if (r_count !== 2'd0) begin
      errors++; $display("FAIL sat_pre_clear: got %0d expected 0", r_count);
    end
    rst = 1'b0; a = 1'b1; b = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick;
      exp_r = CNT_EN ? ((i > 3) ? 3 : i) : 0;
      exp_c = CNT_EN ? i : 0;
      checks++;
      if (r_count !== 2'(exp_r)) begin
        errors++; $display("FAIL sat_count_cyc%0d: got %0d expected %0d", i, r_count, exp_r);
      end
      checks++;
      if (c0_count !== 8'(exp_c)) begin
        errors++; $display("FAIL wide_count_cyc%0d: got %0d expected %0d", i, c0_count, exp_c);
      end
      checks++;
      if ({r_carry, r_sum, r_valid} !== 3'b101) begin
        errors++; $display("FAIL sat_data_cyc%0d: got %b expected 101", i, {r_carry, r_sum, r_valid});
      end
    end
    rst = 1'b1;
    tick;
    checks++;
    if ({r_count, c0_count} !== 10'd0) begin
      errors++; $display("FAIL sat_rst_priority: got %0d/%0d expected 0/0", r_count, c0_count);
    end
    checks++;
    if ({r_carry, r_sum, r_valid} !== 3'b000) begin
      errors++; $display("FAIL sat_rst_outputs: got %b expected 000", {r_carry, r_sum, r_valid});
    end
  endtask

  task automatic test_mid_reset;
    rst = 1'b0; a = 1'b1; b = 1'b0; in_valid = 1'b1;
    tick;
    checks++;
    if ({r_carry, r_sum, r_valid} !== 3'b011) begin
      errors++; $display("FAIL mid_before: got %b expected 011", {r_carry, r_sum, r_valid});
    end
    rst = 1'b1; a = 1'b1; b = 1'b1;
    tick;
    checks++;
    if ({r_carry, r_sum, r_valid, r_count} !== 5'b00000) begin
      errors++; $display("FAIL mid_reset: got %b expected 00000", {r_carry, r_sum, r_valid, r_count});
    end
    rst = 1'b0; a = 1'b0; b = 1'b1;
    tick;
    checks++;
    if ({r_carry, r_sum, r_valid} !== 3'b011) begin
      errors++; $display("FAIL mid_after_01: got %b expected 011", {r_carry, r_sum, r_valid});
    end
    a = 1'b1; b = 1'b1;
    tick;
    checks++;
    if ({r_carry, r_sum, r_valid} !== 3'b101) begin
      errors++; $display("FAIL mid_after_11: got %b expected 101", {r_carry, r_sum, r_valid});
    end
    checks++;
    if (r_count !== (CNT_EN ? 2'd1 : 2'd0)) begin
      errors++; $display("FAIL mid_after_count: got %0d expected %0d", r_count, (CNT_EN ? 1 : 0));
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] vin [4];
    logic [1:0] vexp [4];
    vin  = '{2'b11, 2'b00, 2'b01, 2'b10};
    vexp = '{2'b10, 2'b00, 2'b01, 2'b01};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {a, b} = vin[i];
      tick;
      checks++;
      if ({r_carry, r_sum, r_valid} !== {vexp[i], 1'b1}) begin
        errors++; $display("FAIL b2b_vec%0d: got %b expected %b", i, {r_carry, r_sum, r_valid}, {vexp[i], 1'b1});
      end
    end
  endtask

  initial begin
    rst = 1'b1; a = 1'b0; b = 1'b0; in_valid = 1'b0;
    test_reset;
    test_comb;
    test_reg_basic;
    test_hold;
    test_count_sat;
    test_mid_reset;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
